dlx_mem_arbiter: RTL
====================

Name: dlx_mem_arbiter

Overview:
- Two-port to one-port memory arbiter for a DLX built around a single unified memory (one rwmem-style port).
- Serialises instruction fetches (read-only port I) and load/store accesses (port D) onto one memory port (port M).
- Uses the same ENABLE / READNOTWRITE / DATA_READY handshake the DLX IRAM/DRAM interfaces use.
- Sits between the DLX core and the memory model; adds round-robin arbitration and a stall watchdog.

Parameters:
ADDRESS_SIZE, 32, width of all address buses
WORD_SIZE, 32, width of all data buses
TIMEOUT_CYCLES, 64, max cycles in a BUSY state waiting for M_READY before abort; must be >= 2

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
I_ADDRESS  in  ADDRESS_SIZE  fetch address
I_ENABLE  in  1  fetch request, held until I_READY
I_READY  out  1  one-cycle pulse: fetch complete, I_DATA valid
I_DATA  out  WORD_SIZE  fetched word, registered
D_ADDRESS  in  ADDRESS_SIZE  load/store address
D_ENABLE  in  1  data request, held until D_READY
D_READNOTWRITE  in  1  1=load, 0=store
D_WDATA  in  WORD_SIZE  store data
D_READY  out  1  one-cycle pulse: data access complete
D_RDATA  out  WORD_SIZE  load data, registered
M_ADDRESS  out  ADDRESS_SIZE  memory address, registered
M_ENABLE  out  1  memory request, held until M_READY or timeout
M_READNOTWRITE  out  1  memory direction; 1 for all fetches
M_WDATA  out  WORD_SIZE  memory store data
M_READY  in  1  memory completion; M_RDATA valid in same cycle
M_RDATA  in  WORD_SIZE  memory read data
ERR  out  1  sticky: watchdog abort occurred

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs 0: M_ENABLE, M_ADDRESS, M_WDATA, I_READY, D_READY, I_DATA, D_RDATA, ERR. M_READNOTWRITE=1. last_grant=D, so I wins the first contention. Watchdog count=0.
- Reset asserted mid-access drops M_ENABLE at once; the pending access is lost with no READY pulse. Requesters re-issue after reset.
- FSM states:
  - IDLE: sample I_ENABLE/D_ENABLE at the clock edge.
    - Only one high: grant it.
    - Both high: grant the port opposite last_grant.
    - Grant action: latch address, direction, WDATA into M_* registers; go to BUSY_I or BUSY_D; update last_grant.
    - Neither high: stay.
  - BUSY_I / BUSY_D: M_ENABLE=1, M_* registers stable; watchdog increments each cycle.
    - M_READY=1: capture M_RDATA into I_DATA (BUSY_I) or into D_RDATA (BUSY_D, loads only; stores leave D_RDATA unchanged). Go to DONE; M_ENABLE=0 next cycle.
    - Watchdog reaches TIMEOUT_CYCLES-1 with M_READY=0: go to DONE, set ERR=1, capture data as 0.
  - DONE: one cycle. Pulse I_READY or D_READY (never both), M_ENABLE=0, new requests ignored. Next state IDLE; watchdog clears.
- Requester rule: ENABLE still high in the cycle after its READY pulse is a new request.
- Latency with a memory asserting M_READY k cycles after M_ENABLE rises (k>=0): request sampled at edge 0 -> M_ENABLE high cycles 1..1+k -> READY pulse in cycle 2+k.
- Minimum spacing between accesses on M is 3 cycles (BUSY, DONE, IDLE).
- Fairness: under continuous contention, grants alternate I,D,I,D. No port waits more than one full access of the other port.
- M_READY outside BUSY states is ignored.
- ERR stays set until RST. An aborted access still completes its handshake toward the requester (READY pulse, data 0).
- Requester inputs changing while not granted have no effect. Changes during own grant are ignored (values were latched).

Test Plan:
- Single fetch: I_ENABLE=1, I_ADDRESS=0x0000_0010, memory k=2 returns 0x2002_0004 -> M_ENABLE high cycles 1-3, M_ADDRESS=0x10, M_READNOTWRITE=1, I_READY pulse cycle 4, I_DATA=0x2002_0004, D_READY never high.
- Store: D_ENABLE=1, D_READNOTWRITE=0, D_ADDRESS=0x100, D_WDATA=0xDEAD_BEEF, k=2 -> M_READNOTWRITE=0, M_WDATA=0xDEADBEEF while M_ENABLE high, D_READY pulse cycle 4, D_RDATA unchanged.
- Contention: both ENABLEs held high from reset release, k=0 -> first grant I, then D, then I; READY pulses every 3 cycles, alternating ports.
- Back-to-back: I_ENABLE held high for 4 fetches at 0x0,0x4,0x8,0xC (address updated on each READY), k=0 -> 4 I_READY pulses 3 cycles apart, correct data each.
- Watchdog: TIMEOUT_CYCLES=8, memory never asserts M_READY on a load -> M_ENABLE high exactly 8 cycles, D_READY pulse with D_RDATA=0, ERR=1 and held until RST.
- Async reset mid-access: RST high during BUSY_D between clock edges -> M_ENABLE and all outputs 0 immediately, no D_READY; after release with both requesting, I granted first.

Source files
------------

// File: rtl/dlx_mem_arbiter.sv
// Two-port (fetch / load-store) to one-port memory arbiter for a unified-memory DLX.
// Round-robin grant on contention, registered handshakes, and a stall watchdog that aborts hung accesses.
module dlx_mem_arbiter #(
    parameter int ADDRESS_SIZE   = 32,
    parameter int WORD_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [ADDRESS_SIZE-1:0] I_ADDRESS,
    input  logic                    I_ENABLE,
    output logic                    I_READY,
    output logic [WORD_SIZE-1:0]    I_DATA,
    input  logic [ADDRESS_SIZE-1:0] D_ADDRESS,
    input  logic                    D_ENABLE,
    input  logic                    D_READNOTWRITE,
    input  logic [WORD_SIZE-1:0]    D_WDATA,
    output logic                    D_READY,
    output logic [WORD_SIZE-1:0]    D_RDATA,
    output logic [ADDRESS_SIZE-1:0] M_ADDRESS,
    output logic                    M_ENABLE,
    output logic                    M_READNOTWRITE,
    output logic [WORD_SIZE-1:0]    M_WDATA,
    input  logic                    M_READY,
    input  logic [WORD_SIZE-1:0]    M_RDATA,
    output logic                    ERR
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_I = 2'd1;
    localparam logic [1:0] S_BUSY_D = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]      state;
    logic            last_d;
    logic [WD_W-1:0] wd_cnt;
    logic            pick_d;
    logic            finish;
    logic [WORD_SIZE-1:0] cap_data;

    // D wins only when alone or when I held the previous grant.
    assign pick_d   = D_ENABLE && (!I_ENABLE || !last_d);
    assign finish   = M_READY || (wd_cnt == WD_LAST);
    // An aborted access hands back zero rather than whatever is on the bus.
    assign cap_data = M_READY ? M_RDATA : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= S_IDLE;
            last_d         <= 1'b1;
            wd_cnt         <= '0;
            M_ADDRESS      <= '0;
            M_ENABLE       <= 1'b0;
            M_READNOTWRITE <= 1'b1;
            M_WDATA        <= '0;
            I_READY        <= 1'b0;
            D_READY        <= 1'b0;
            I_DATA         <= '0;
            D_RDATA        <= '0;
            ERR            <= 1'b0;
        end else begin
            I_READY <= 1'b0;
            D_READY <= 1'b0;
            case (state)
                S_IDLE: begin
                    wd_cnt <= '0;
                    if (I_ENABLE || D_ENABLE) begin
                        M_ENABLE <= 1'b1;
                        last_d   <= pick_d;
                        if (pick_d) begin
                            M_ADDRESS      <= D_ADDRESS;
                            M_READNOTWRITE <= D_READNOTWRITE;
                            M_WDATA        <= D_WDATA;
                            state          <= S_BUSY_D;
                        end else begin
                            M_ADDRESS      <= I_ADDRESS;
                            M_READNOTWRITE <= 1'b1;
                            state          <= S_BUSY_I;
                        end
                    end
                end
                S_BUSY_I, S_BUSY_D: begin
                    if (finish) begin
                        M_ENABLE <= 1'b0;
                        state    <= S_DONE;
                        if (!M_READY) ERR <= 1'b1;
                        if (state == S_BUSY_I) begin
                            I_READY <= 1'b1;
                            I_DATA  <= cap_data;
                        end else begin
                            D_READY <= 1'b1;
                            if (M_READNOTWRITE) D_RDATA <= cap_data;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    wd_cnt <= '0;
                end
            endcase
        end
    end
endmodule
